atmega_pll_ce: RTL and testbench
================================

// Module: atmega_pll_ce
// PURPOSE
//  Multi-channel PLL-style clock-enable generator for the ATMEGA peripheral set. Replaces divided
//  clocks with single-cycle enable pulses in the clk_i domain, each channel with an integer+fractional
//  divisor (Bresenham accumulator) and an emulated lock sequence. Sits on the IO bus beside the
//  timers/USB; timers consume ce_o[k] as their count enable.
// PARAMETERS
//  BUS_ADDR_DATA_LEN  16     IO address width
//  CSR_ADDR           'h49   control/status register address
//  DIV_BASE_ADDR      'h52   channel k: DIVI at base+2k, DIVF at base+2k+1
//  CHANNELS           2      number of enable channels, 1..4
//  FRAC_W             8      fractional accumulator width, 1..8 (DIVF[FRAC_W-1:0] used)
//  LOCK_CYCLES        64     clk_i cycles from PLLE rise to LOCK, >=1
// PORTS
//  clk_i      in   1                  system clock, sole clock
//  rst_ni     in   1                  reset, asynchronous, active-low
//  addr_i     in   BUS_ADDR_DATA_LEN  IO address
//  wr_i       in   1                  write strobe, sampled on clk_i
//  rd_i       in   1                  read strobe
//  bus_i      in   8                  write data
//  bus_o      out  8                  read data, combinational, 0 when no hit
//  lock_o     out  1                  CSR.LOCK
//  ce_o       out  CHANNELS           per-channel 1-cycle enable pulses
// BEHAVIOUR
//  - Reset (async assert, sync release): CSR/DIVI/DIVF/counters/accumulators = 0; lock_o=0, ce_o=0.
//  - CSR: [0] LOCK RO; [1] PLLE; [3:2] reserved, read 0; [4+k] CHE[k] (bits >= 4+CHANNELS read 0).
//    Writes to LOCK/reserved bits ignored.
//  - Lock: PLLE 0->1 loads lock_cnt=LOCK_CYCLES, LOCK=0; decrements each cycle; LOCK=1 the cycle after
//    lock_cnt reaches 0. Writing PLLE=1 while already 1 does not restart. PLLE=0 -> LOCK=0 next cycle,
//    all channel counters/accumulators cleared.
//  - Channel k active when LOCK & CHE[k]. Inactive: ce_o[k]=0, cnt=0, acc=0.
//  - Period P = max(DIVI,1) + carry, carry = overflow of acc + DIVF[FRAC_W-1:0] (mod 2^FRAC_W).
//    Mean period = max(DIVI,1) + DIVF/2^FRAC_W cycles.
//  - First ce_o[k] pulse exactly 1 cycle after channel becomes active (cnt=0 on entry); on each pulse
//    latch shadow DIVI/DIVF, update acc, reload cnt=P-1; else cnt--.
//  - DIVI/DIVF writes take effect at the next pulse, never mid-period. DIVI=0 behaves as DIVI=1.
//  - CHE[k] cleared mid-period: ce_o[k]=0 next cycle, state cleared; re-set restarts phase as above.
//  - Write and read same address same cycle: bus_o shows old value.
//  - Reset mid-operation: all outputs 0 immediately (async), no pulse emitted on reset release cycle.
//  - Address hits outside CHANNELS range: writes ignored, reads 0.
// CONFIGURATION
//  ATMEGA_PLL_CE_TOGGLE_EN defined: extra port tgl_o[CHANNELS] (out), registered, toggles on every
//    ce_o[k] pulse, reset 0, held while channel inactive: ~50% duty divided clock for USB/debug.
//  Undefined: tgl_o port and its logic absent; all other behaviour identical.
// TESTING
//  1 Reset: rst_ni=0 mid-run with CHE=1 -> lock_o=0, ce_o=0, all regs read 0 immediately.
//  2 Lock: LOCK_CYCLES=64, write CSR=0x12 -> lock_o rises 65 cycles later; first ce_o[0] next cycle.
//  3 Integer: DIVI0=4, DIVF0=0 -> ce_o[0] every 4 cycles exactly; DIVI0=0 -> every cycle.
//  4 Fraction: FRAC_W=8, DIVI1=3, DIVF1=0x40 -> periods 3,3,3,4 repeating; 1024 pulses in 3328 cycles.
//  5 Retune: write DIVI0=2 mid-period of DIVI0=10 -> current period stays 10, following periods 2.
//  6 Disable: write CSR PLLE=0 while running -> lock_o=0 and ce_o=0 next cycle; re-enable relocks 64.

Source files
------------

// File: rtl/atmega_pll_ce.sv
// atmega_pll_ce: per-channel clock-enable generator with integer+fraction
// divisors and an emulated PLL lock sequence, mapped on the ATMEGA IO bus.
//
// Ports:
//   clk_i   : system clock (sole clock)
//   rst_ni  : asynchronous active-low reset
//   addr_i  : IO address
//   wr_i    : write strobe, sampled on clk_i
//   rd_i    : read strobe
//   bus_i   : write data
//   bus_o   : read data, combinational, 0 when no read hit
//   lock_o  : CSR.LOCK
//   ce_o    : per-channel single-cycle enable pulses
//   tgl_o   : per-channel toggle outputs (only with ATMEGA_PLL_CE_TOGGLE_EN)
//
// Build option ATMEGA_PLL_CE_TOGGLE_EN adds tgl_o, which flips on every
// ce_o pulse to give a ~50% duty divided clock.

module atmega_pll_ce #(
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int CSR_ADDR          = 'h49,
  parameter int DIV_BASE_ADDR     = 'h52,
  parameter int CHANNELS          = 2,
  parameter int FRAC_W            = 8,
  parameter int LOCK_CYCLES       = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  output logic                         lock_o,
  output logic [CHANNELS-1:0]          ce_o
`ifdef ATMEGA_PLL_CE_TOGGLE_EN
  ,
  output logic [CHANNELS-1:0]          tgl_o
`endif
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    LK_OFF,
    LK_WAIT,
    LK_ON
  } lk_e;

  lk_e lk_q;
  lk_e lk_d;

  logic                plle_q;
  logic [CHANNELS-1:0] che_q;
  logic [LCW-1:0]      lock_cnt_q;

  logic [7:0]        divi_q [CHANNELS];
  logic [7:0]        divf_q [CHANNELS];
  logic [7:0]        cnt_q  [CHANNELS];
  logic [FRAC_W-1:0] acc_q  [CHANNELS];
  logic [CHANNELS-1:0] ce_q;

  logic                csr_hit;
  logic                csr_wr;
  logic                plle_rise;
  logic                plle_fall;
  logic [CHANNELS-1:0] divi_hit;
  logic [CHANNELS-1:0] divf_hit;
  logic [CHANNELS-1:0] go;
  logic [FRAC_W:0]     sum_w  [CHANNELS];
  logic [7:0]          rel    [CHANNELS];
  logic [7:0]          csr_val;
  logic [7:0]          rdata;

  // Address decode
  assign csr_hit = addr_i == BUS_ADDR_DATA_LEN'(CSR_ADDR);
  assign csr_wr  = wr_i & csr_hit;

  always_comb begin
    divi_hit = '0;
    divf_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      divi_hit[k] = addr_i ==
        BUS_ADDR_DATA_LEN'(DIV_BASE_ADDR + 2 * k);
      divf_hit[k] = addr_i ==
        BUS_ADDR_DATA_LEN'(DIV_BASE_ADDR + 2 * k + 1);
    end
  end

  // CSR
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      plle_q <= 1'b0;
      che_q  <= '0;
    end else if (csr_wr) begin
      plle_q <= bus_i[1];
      che_q  <= bus_i[4 +: CHANNELS];
    end
  end

  // Divisor registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < CHANNELS; k++) begin
        divi_q[k] <= '0;
        divf_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_i && divi_hit[k]) divi_q[k] <= bus_i;
        if (wr_i && divf_hit[k]) divf_q[k] <= bus_i;
      end
    end
  end

  // Lock sequencer
  assign plle_rise = csr_wr & bus_i[1] & ~plle_q;
  assign plle_fall = csr_wr & ~bus_i[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lk_q <= LK_OFF;
    end else begin
      lk_q <= lk_d;
    end
  end

  always_comb begin
    lk_d = lk_q;
    unique case (lk_q)
      LK_OFF: begin
        if (plle_rise) lk_d = LK_WAIT;
      end
      LK_WAIT: begin
        if (plle_fall) lk_d = LK_OFF;
        else if (lock_cnt_q == '0) lk_d = LK_ON;
      end
      LK_ON: begin
        if (plle_fall) lk_d = LK_OFF;
      end
      default: lk_d = LK_OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_cnt_q <= '0;
    end else if (plle_rise) begin
      lock_cnt_q <= LCW'(LOCK_CYCLES);
    end else if (lk_q == LK_WAIT && lock_cnt_q != '0) begin
      lock_cnt_q <= lock_cnt_q - 1'b1;
    end
  end

  assign lock_o = lk_q == LK_ON;

  // Channel datapath.
  // A CSR write that drops PLLE or CHE[k] kills the channel on the
  // same edge, so ce_o is already low in the following cycle.
  always_comb begin
    go = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum_w[k] = {1'b0, acc_q[k]} +
                 {1'b0, divf_q[k][FRAC_W-1:0]};
      rel[k]   = ((divi_q[k] == 8'd0) ? 8'd0 : divi_q[k] - 8'd1) +
                 {7'd0, sum_w[k][FRAC_W]};
      go[k]    = lock_o & che_q[k] &
                 ~(csr_wr & ~(bus_i[1] & bus_i[4+k]));
    end
  end

  // The divisor registers are sampled only at a pulse, so retunes
  // never shorten or stretch the period already in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!go[k]) begin
          ce_q[k]  <= 1'b0;
          cnt_q[k] <= '0;
          acc_q[k] <= '0;
        end else if (cnt_q[k] == 8'd0) begin
          ce_q[k]  <= 1'b1;
          cnt_q[k] <= rel[k];
          acc_q[k] <= sum_w[k][FRAC_W-1:0];
        end else begin
          ce_q[k]  <= 1'b0;
          cnt_q[k] <= cnt_q[k] - 8'd1;
        end
      end
    end
  end

  assign ce_o = ce_q;

`ifdef ATMEGA_PLL_CE_TOGGLE_EN
  logic [CHANNELS-1:0] tgl_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgl_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (go[k] && cnt_q[k] == 8'd0) tgl_q[k] <= ~tgl_q[k];
      end
    end
  end

  assign tgl_o = tgl_q;
`endif

  // Read mux
  always_comb begin
    csr_val = '0;
    csr_val[0] = lock_o;
    csr_val[1] = plle_q;
    csr_val[4 +: CHANNELS] = che_q;
  end

  always_comb begin
    rdata = '0;
    if (rd_i) begin
      if (csr_hit) rdata = csr_val;
      for (int k = 0; k < CHANNELS; k++) begin
        if (divi_hit[k]) rdata = divi_q[k];
        if (divf_hit[k]) rdata = divf_q[k];
      end
    end
  end

  assign bus_o = rdata;

endmodule

// File: tb/tb_atmega_pll_ce.sv
// tb_atmega_pll_ce: directed + randomized bench for atmega_pll_ce.
// Pulse trains are predicted from the closed-form period rule.

module tb_atmega_pll_ce;

  localparam int HMAX = 16384;
  localparam logic [15:0] CSR   = 16'h0049;
  localparam logic [15:0] DIVI0 = 16'h0052;
  localparam logic [15:0] DIVF0 = 16'h0053;
  localparam logic [15:0] DIVI1 = 16'h0054;
  localparam logic [15:0] DIVF1 = 16'h0055;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] addr_i;
  logic        wr_i;
  logic        rd_i;
  logic [7:0]  bus_i;
  logic [7:0]  bus_o;
  logic        lock_o;
  logic [1:0]  ce_o;
`ifdef ATMEGA_PLL_CE_TOGGLE_EN
  logic [1:0]  tgl_o;
`endif

  atmega_pll_ce dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i (addr_i),
    .wr_i   (wr_i),
    .rd_i   (rd_i),
    .bus_i  (bus_i),
    .bus_o  (bus_o),
    .lock_o (lock_o),
    .ce_o   (ce_o)
`ifdef ATMEGA_PLL_CE_TOGGLE_EN
    ,
    .tgl_o  (tgl_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // hist[k] holds the outputs as they stand after posedge number k
  logic       lock_h [HMAX];
  logic [1:0] ce_h   [HMAX];
  bit         exp_b  [HMAX];

  always @(negedge clk_i) begin
    if (cyc < HMAX) begin
      lock_h[cyc] = lock_o;
      ce_h[cyc]   = ce_o;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d,
                    output int en);
    @(negedge clk_i);
    addr_i = a;
    bus_i  = d;
    wr_i   = 1'b1;
    @(posedge clk_i);
    #1;
    wr_i = 1'b0;
    en   = cyc;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk_i);
    addr_i = a;
    rd_i   = 1'b1;
    #1;
    d    = bus_o;
    rd_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Pulse n lands at t0 + n*d + floor(n*f/256); every other cycle in
  // [from,to) must be quiet.
  task automatic chk_chan(input string tag, input int ch, input int t0,
                          input int d, input int f,
                          input int from, input int to);
    int bad;
    int n;
    int t;
    bad = 0;
    n = 0;
    for (int c = from; c < to; c++) exp_b[c] = 1'b0;
    t = t0;
    while (t < to) begin
      if (t >= from) exp_b[t] = 1'b1;
      n++;
      t = t0 + n * d + (n * f) / 256;
    end
    for (int c = from; c < to; c++) begin
      if (ce_h[c][ch] !== exp_b[c]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  int w, wl, wc, we, wc2, ee, wr2, wd, e, wp, wq;
  int d0, f0, d1, f1, cnt;
  logic [7:0] rv;

  initial begin
    addr_i = '0;
    wr_i   = 1'b0;
    rd_i   = 1'b0;
    bus_i  = '0;
    d0 = 4; f0 = 0; d1 = 3; f1 = 64;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_lock", lock_o, 0);
    chk("rst_ce", ce_o, 0);
    rst_ni = 1'b1;
    rd(CSR, rv);
    chk("rst_csr", rv, 0);
    rd(DIVI0, rv);
    chk("rst_divi0", rv, 0);

    wr(DIVI0, 8'd4, w);
    wr(DIVF0, 8'd0, w);
    wr(DIVI1, 8'd3, w);
    wr(DIVF1, 8'h40, w);
    rd(DIVF1, rv);
    chk("rd_divf1", rv, 8'h40);

    // lock and long fractional run
    wr(CSR, 8'h32, wl);
    wait_until(wl + 66 + 3400);
    chk("lock_pre", lock_h[wl+64], 0);
    chk("lock_rise", lock_h[wl+65], 1);
    chk("first_ce0", ce_h[wl+66][0], 1);
    chk_chan("int_div4", 0, wl + 66, 4, 0, wl, cyc);
    chk_chan("frac_3_40", 1, wl + 66, 3, 64, wl, cyc);
    cnt = 0;
    for (int c = wl + 66; c < wl + 66 + 3328; c++) cnt += int'(ce_h[c][1]);
    chk("frac_count", cnt, 1024);

    // DIVI=0 behaves as 1, after a CHE drop/restart
    wr(CSR, 8'h22, wc);
    wr(DIVI0, 8'd0, w);
    wr(CSR, 8'h32, we);
    wait_until(we + 30);
    chk_chan("divi0_every", 0, we + 1, 1, 0, wc, cyc);

    // retune mid-period
    wr(CSR, 8'h22, wc2);
    wr(DIVI0, 8'd10, w);
    wr(CSR, 8'h32, ee);
    wait_until(ee + 13);
    wr(DIVI0, 8'd2, wr2);
    chk("retune_mid", (wr2 > ee + 11 && wr2 < ee + 21), 1);
    wait_until(ee + 70);
    chk_chan("retune_old", 0, ee + 1, 10, 0, wc2, ee + 22);
    chk_chan("retune_new", 0, ee + 21, 2, 0, ee + 21, cyc);
    chk_chan("frac_cont", 1, wl + 66, 3, 64, wl, cyc);

    // randomized divisors
    for (int it = 0; it < 4; it++) begin
      wr(CSR, 8'h02, wd);
      d0 = $urandom_range(0, 7);
      f0 = $urandom_range(0, 255);
      d1 = $urandom_range(0, 7);
      f1 = $urandom_range(0, 255);
      wr(DIVI0, 8'(d0), w);
      wr(DIVF0, 8'(f0), w);
      wr(DIVI1, 8'(d1), w);
      wr(DIVF1, 8'(f1), w);
      wr(CSR, 8'h32, e);
      wait_until(e + 300);
      chk_chan($sformatf("rnd%0d_ch0", it), 0, e + 1, eff(d0), f0, wd, cyc);
      chk_chan($sformatf("rnd%0d_ch1", it), 1, e + 1, eff(d1), f1, wd, cyc);
    end

    // PLLE drop and relock
    wr(CSR, 8'h30, wp);
    wait_until(wp + 20);
    chk("off_lock_prev", lock_h[wp-1], 1);
    chk("off_lock", lock_h[wp], 0);
    cnt = 0;
    for (int c = wp; c < wp + 19; c++) cnt += int'(ce_h[c] != 2'b00);
    chk("off_ce", cnt, 0);
    rd(CSR, rv);
    chk("off_csr", rv, 8'h30);
    wr(CSR, 8'h32, wq);
    wait_until(wq + 300);
    chk("relock_pre", lock_h[wq+64], 0);
    chk("relock_rise", lock_h[wq+65], 1);
    chk_chan("relock_ch0", 0, wq + 66, eff(d0), f0, wp, cyc);
    chk_chan("relock_ch1", 1, wq + 66, eff(d1), f1, wp, cyc);

    // same-cycle write and read of one register
    @(negedge clk_i);
    addr_i = DIVI1;
    bus_i  = 8'h77;
    wr_i   = 1'b1;
    rd_i   = 1'b1;
    #1;
    chk("rw_old", bus_o, 8'(d1));
    @(posedge clk_i);
    #1;
    wr_i = 1'b0;
    chk("rw_new", bus_o, 8'h77);
    rd_i = 1'b0;

    // unmapped addresses
    wr(16'h0056, 8'h55, w);
    rd(16'h0056, rv);
    chk("oor_56", rv, 0);
    rd(16'h0057, rv);
    chk("oor_57", rv, 0);
    rd(16'h0040, rv);
    chk("unmapped_40", rv, 0);

    // reserved/RO CSR bits, PLLE rewrite does not restart lock
    wr(CSR, 8'hFF, w);
    rd(CSR, rv);
    chk("csr_ff", rv, 8'h33);
    repeat (3) @(posedge clk_i);
    #1;
    chk("no_restart", lock_o, 1);

    // asynchronous reset mid-run
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_lock", lock_o, 0);
    chk("arst_ce", ce_o, 0);
    rd_i   = 1'b1;
    addr_i = CSR;
    #1;
    chk("arst_csr", bus_o, 0);
    addr_i = DIVI1;
    #1;
    chk("arst_divi1", bus_o, 0);
    rd_i = 1'b0;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    w = cyc;
    wait_until(w + 6);
    cnt = 0;
    for (int c = w; c < w + 5; c++) cnt += int'(ce_h[c] != 2'b00);
    chk("post_rst_ce", cnt, 0);
    chk("post_rst_lock", lock_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
